// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU controller: opcodes, instruction
// field positions and the sequencing state type.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'h3;
  localparam logic [3:0] OP_JZ    = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RW_MSB    = 11;
  localparam int RW_LSB    = 8;
  localparam int RA_MSB    = 7;
  localparam int RA_LSB    = 4;
  localparam int RB_MSB    = 3;
  localparam int RB_LSB    = 0;
  localparam int ADDR8_MSB = 7;
  localparam int ADDR8_LSB = 0;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    LD_WB,
    HALTED
  } state_t;

  // The whole upper half of the opcode space is ALU operations
  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of (state, ir) into the datapath control signals.
// With CTRL_BRANCH_EN defined it also flags JZ/JMP in EXEC for the pc logic.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
`ifdef CTRL_BRANCH_EN
  output logic                jump,
  output logic                jump_if_zero,
`endif
  input  state_t              state,
  input  logic [WIDTH-1:0]    ir,
  output logic [D_ADDR_W-1:0] d_addr,
  output logic                d_wr,
  output logic [R_ADDR_W-1:0] rf_w_addr,
  output logic [R_ADDR_W-1:0] rf_a_addr,
  output logic [R_ADDR_W-1:0] rf_b_addr,
  output logic                rf_w_en,
  output logic                rf_s,
  output logic [3:0]          alu_sel,
  output logic                halted
);

  logic [3:0] op;
  logic [3:0] rw;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [7:0] addr8;

  always_comb begin
    op    = ir[OP_MSB:OP_LSB];
    rw    = ir[RW_MSB:RW_LSB];
    ra    = ir[RA_MSB:RA_LSB];
    rb    = ir[RB_MSB:RB_LSB];
    addr8 = ir[ADDR8_MSB:ADDR8_LSB];

    d_addr    = '0;
    d_wr      = 1'b0;
    rf_w_en   = 1'b0;
    rf_s      = 1'b0;
    halted    = 1'b0;
`ifdef CTRL_BRANCH_EN
    jump         = 1'b0;
    jump_if_zero = 1'b0;
`endif
    rf_w_addr = R_ADDR_W'(rw);
    rf_b_addr = R_ADDR_W'(rb);
    rf_a_addr = R_ADDR_W'(ra);
    alu_sel   = is_alu_op(op) ? {1'b0, op[2:0]} : 4'h0;

    // STORE and JZ read the register named by rw through port A
    if (op == OP_STORE)
      rf_a_addr = R_ADDR_W'(rw);
`ifdef CTRL_BRANCH_EN
    if (op == OP_JZ)
      rf_a_addr = R_ADDR_W'(rw);
`endif

    unique case (state)
      EXEC: begin
        case (op)
          OP_STORE: begin
            d_wr   = 1'b1;
            d_addr = D_ADDR_W'(addr8);
          end
          OP_LOAD:  d_addr = D_ADDR_W'(addr8);
`ifdef CTRL_BRANCH_EN
          OP_JZ:    jump_if_zero = 1'b1;
          OP_JMP:   jump = 1'b1;
`endif
          OP_NOOP, OP_HALT: ;
          default:  rf_w_en = is_alu_op(op);
        endcase
      end
      LD_WB: begin
        d_addr  = D_ADDR_W'(addr8);
        rf_s    = 1'b1;
        rf_w_en = 1'b1;
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: holds state, pc and ir and drives the datapath via
// instr_decode. Define CTRL_BRANCH_EN to enable JZ/JMP; otherwise they are NOOPs.
module control_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4,
  parameter int PC_W     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PC_W-1:0]     I_addr,
  input  logic [WIDTH-1:0]    I_data,
  input  logic [WIDTH-1:0]    ALU_A,
  output logic [D_ADDR_W-1:0] D_addr,
  output logic                D_wr,
  output logic [R_ADDR_W-1:0] RF_W_addr,
  output logic [R_ADDR_W-1:0] RF_A_addr,
  output logic [R_ADDR_W-1:0] RF_B_addr,
  output logic                RF_W_en,
  output logic                RF_s,
  output logic [3:0]          ALU_sel,
  output logic                halted
);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [WIDTH-1:0] ir;
  logic [3:0]       op;

  assign op = ir[OP_MSB:OP_LSB];

  // pc advances in DECODE, so later states show the address of the
  // instruction in flight until the next fetch
  assign I_addr = (state == FETCH || state == DECODE) ? pc : pc - PC_W'(1);

`ifdef CTRL_BRANCH_EN
  logic            jump;
  logic            jump_if_zero;
  logic            branch_taken;
  logic [PC_W-1:0] target;

  assign target       = PC_W'(ir[ADDR8_MSB:ADDR8_LSB]);
  assign branch_taken = jump || (jump_if_zero && (ALU_A == '0));
`else
  logic unused_alu_a;
  assign unused_alu_a = ^ALU_A;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= I_data;
          pc    <= pc + PC_W'(1);
          state <= EXEC;
        end
        EXEC: begin
`ifdef CTRL_BRANCH_EN
          if (branch_taken)
            pc <= target;
`endif
          if (op == OP_LOAD)
            state <= LD_WB;
          else if (op == OP_HALT)
            state <= HALTED;
          else
            state <= FETCH;
        end
        LD_WB:  state <= FETCH;
        HALTED: state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  instr_decode #(
    .WIDTH    (WIDTH),
    .D_ADDR_W (D_ADDR_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_decode (
`ifdef CTRL_BRANCH_EN
    .jump         (jump),
    .jump_if_zero (jump_if_zero),
`endif
    .state        (state),
    .ir           (ir),
    .d_addr       (D_addr),
    .d_wr         (D_wr),
    .rf_w_addr    (RF_W_addr),
    .rf_a_addr    (RF_A_addr),
    .rf_b_addr    (RF_B_addr),
    .rf_w_en      (RF_W_en),
    .rf_s         (RF_s),
    .alu_sel      (ALU_sel),
    .halted       (halted)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: single-instruction vectors through a
// scoreboard, plus hand sequences for reset, HALT at 0xFF and reset mid-LOAD.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  I_addr;
  logic [15:0] I_data = 16'h0000;
  logic [15:0] ALU_A = 16'h0000;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_A_addr;
  logic [3:0]  RF_B_addr;
  logic        RF_W_en;
  logic        RF_s;
  logic [3:0]  ALU_sel;
  logic        halted;

  logic [15:0] rom [0:255];

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [7:0] i_addr;
    logic [7:0] d_addr;
    logic       d_wr;
    logic [3:0] rf_w_addr;
    logic [3:0] rf_a_addr;
    logic [3:0] rf_b_addr;
    logic       rf_w_en;
    logic       rf_s;
    logic [3:0] alu_sel;
    logic       halted;
  } sample_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [7:0]  d_addr;
    logic [3:0]  rf_a;
    logic [3:0]  rf_b;
    logic [3:0]  rf_w;
    logic [3:0]  alu_sel;
    int          wr_cnt;
    int          wen_cnt;
    int          daddr_cycles;
    int          cycles;
    logic [7:0]  next_iaddr;
  } vec_t;

  sample_t trace [8];
  vec_t    vectors [10];
  vec_t    sb_q [$];

  control_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .I_addr    (I_addr),
    .I_data    (I_data),
    .ALU_A     (ALU_A),
    .D_addr    (D_addr),
    .D_wr      (D_wr),
    .RF_W_addr (RF_W_addr),
    .RF_A_addr (RF_A_addr),
    .RF_B_addr (RF_B_addr),
    .RF_W_en   (RF_W_en),
    .RF_s      (RF_s),
    .ALU_sel   (ALU_sel),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: data appears one cycle after the address
  always @(posedge clk) I_data <= rom[I_addr];

  function automatic sample_t takeSample();
    sample_t s;
    s.i_addr    = I_addr;
    s.d_addr    = D_addr;
    s.d_wr      = D_wr;
    s.rf_w_addr = RF_W_addr;
    s.rf_a_addr = RF_A_addr;
    s.rf_b_addr = RF_B_addr;
    s.rf_w_en   = RF_W_en;
    s.rf_s      = RF_s;
    s.alu_sel   = ALU_sel;
    s.halted    = halted;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Leaves reset released right after a falling edge, state still FETCH
  task automatic doReset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic captureTrace();
    for (int i = 0; i < 8; i++) begin
      trace[i] = takeSample();
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clearRom();
    rom[0] = v.instr;
    ALU_A = v.alu_a;
    sb_q.push_back(v);
    doReset();
    captureTrace();
  endtask

  task automatic checkVector();
    vec_t e;
    int wr_cnt = 0;
    int wen_cnt = 0;
    int dcyc = 0;
    e = sb_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      wr_cnt  += int'(trace[i].d_wr);
      wen_cnt += int'(trace[i].rf_w_en);
      if (trace[i].d_addr != 8'h00) dcyc++;
    end
    checkOutput({e.name, " exec D_addr"}, 32'(trace[2].d_addr), 32'(e.d_addr));
    checkOutput({e.name, " RF_A_addr"}, 32'(trace[2].rf_a_addr), 32'(e.rf_a));
    checkOutput({e.name, " RF_B_addr"}, 32'(trace[2].rf_b_addr), 32'(e.rf_b));
    checkOutput({e.name, " RF_W_addr"}, 32'(trace[2].rf_w_addr), 32'(e.rf_w));
    checkOutput({e.name, " ALU_sel"}, 32'(trace[2].alu_sel), 32'(e.alu_sel));
    checkOutput({e.name, " exec RF_s"}, 32'(trace[2].rf_s), 32'(0));
    checkOutput({e.name, " D_wr pulses"}, 32'(wr_cnt), 32'(e.wr_cnt));
    checkOutput({e.name, " RF_W_en pulses"}, 32'(wen_cnt), 32'(e.wen_cnt));
    checkOutput({e.name, " D_addr cycles"}, 32'(dcyc), 32'(e.daddr_cycles));
    checkOutput({e.name, " next I_addr"}, 32'(trace[e.cycles].i_addr), 32'(e.next_iaddr));
    if (e.cycles == 4) begin
      checkOutput({e.name, " LD_WB RF_s"}, 32'(trace[3].rf_s), 32'(1));
      checkOutput({e.name, " LD_WB RF_W_en"}, 32'(trace[3].rf_w_en), 32'(1));
      checkOutput({e.name, " LD_WB D_addr"}, 32'(trace[3].d_addr), 32'(e.d_addr));
    end
  endtask

  initial begin
    sample_t s;
    int changes;
    logic br;
`ifdef CTRL_BRANCH_EN
    br = 1'b1;
`else
    br = 1'b0;
`endif

    //            name     instr     alu_a    d_addr a     b     w     alu   wr wen dc cyc next
    vectors[0] = '{"NOOP",  16'h0000, 16'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3, 8'h01};
    vectors[1] = '{"LOAD",  16'h220B, 16'h0, 8'h0B, 4'h0, 4'hB, 4'h2, 4'h0, 0, 1, 2, 4, 8'h01};
    vectors[2] = '{"ALU1",  16'h9301, 16'h0, 8'h00, 4'h0, 4'h1, 4'h3, 4'h1, 0, 1, 0, 3, 8'h01};
    vectors[3] = '{"STORE", 16'h14CD, 16'h0, 8'hCD, 4'h4, 4'hD, 4'h4, 4'h0, 1, 0, 1, 3, 8'h01};
    vectors[4] = '{"JZ0",   16'h4120, 16'h0, 8'h00, br ? 4'h1 : 4'h2, 4'h0, 4'h1, 4'h0,
                   0, 0, 0, 3, br ? 8'h20 : 8'h01};
    vectors[5] = '{"JZ5",   16'h4120, 16'h5, 8'h00, br ? 4'h1 : 4'h2, 4'h0, 4'h1, 4'h0,
                   0, 0, 0, 3, 8'h01};
    vectors[6] = '{"JMP",   16'h5077, 16'h5, 8'h00, 4'h7, 4'h7, 4'h0, 4'h0,
                   0, 0, 0, 3, br ? 8'h77 : 8'h01};
    vectors[7] = '{"ALU7",  16'hF5A3, 16'h0, 8'h00, 4'hA, 4'h3, 4'h5, 4'h7, 0, 1, 0, 3, 8'h01};
    vectors[8] = '{"OP6",   16'h6123, 16'h0, 8'h00, 4'h2, 4'h3, 4'h1, 4'h0, 0, 0, 0, 3, 8'h01};
    vectors[9] = '{"ALU0",  16'h8000, 16'h0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 3, 8'h01};

    // Reset: everything zero while held, then I_addr 0,0,0,1
    clearRom();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    s = takeSample();
    checkOutput("reset I_addr", 32'(s.i_addr), 32'(0));
    checkOutput("reset D_addr", 32'(s.d_addr), 32'(0));
    checkOutput("reset D_wr", 32'(s.d_wr), 32'(0));
    checkOutput("reset RF_W_addr", 32'(s.rf_w_addr), 32'(0));
    checkOutput("reset RF_A_addr", 32'(s.rf_a_addr), 32'(0));
    checkOutput("reset RF_B_addr", 32'(s.rf_b_addr), 32'(0));
    checkOutput("reset RF_W_en", 32'(s.rf_w_en), 32'(0));
    checkOutput("reset RF_s", 32'(s.rf_s), 32'(0));
    checkOutput("reset ALU_sel", 32'(s.alu_sel), 32'(0));
    checkOutput("reset halted", 32'(s.halted), 32'(0));
    reset_n = 1'b1;
    captureTrace();
    checkOutput("post-reset I_addr c0", 32'(trace[0].i_addr), 32'(0));
    checkOutput("post-reset I_addr c1", 32'(trace[1].i_addr), 32'(0));
    checkOutput("post-reset I_addr c2", 32'(trace[2].i_addr), 32'(0));
    checkOutput("post-reset I_addr c3", 32'(trace[3].i_addr), 32'(1));

    // Single-instruction vectors
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vectors[v]);
      checkVector();
    end
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'(0));

    // HALT fetched from the last ROM address
    clearRom();
    rom[8'hFF] = 16'h3000;
    ALU_A = 16'h0000;
    doReset();
    repeat (765) @(negedge clk);
    checkOutput("halt fetch I_addr", 32'(I_addr), 32'(8'hFF));
    checkOutput("halt pre halted", 32'(halted), 32'(0));
    repeat (3) @(negedge clk);
    checkOutput("halted flag", 32'(halted), 32'(1));
    checkOutput("halted I_addr", 32'(I_addr), 32'(8'hFF));
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (I_addr != 8'hFF || !halted || RF_W_en || D_wr || RF_s) changes++;
    end
    checkOutput("halted stays put", 32'(changes), 32'(0));

    // Reset pulse in the EXEC cycle of a LOAD
    clearRom();
    rom[0] = 16'h220B;
    doReset();
    repeat (2) @(negedge clk);
    checkOutput("mid-load exec D_addr", 32'(D_addr), 32'(8'h0B));
    reset_n = 1'b0;
    rom[0] = 16'h0000;
    #1;
    checkOutput("mid-load reset RF_W_en", 32'(RF_W_en), 32'(0));
    checkOutput("mid-load reset I_addr", 32'(I_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    captureTrace();
    changes = 0;
    for (int i = 0; i < 8; i++) changes += int'(trace[i].rf_w_en);
    checkOutput("mid-load no RF_W_en", 32'(changes), 32'(0));
    checkOutput("mid-load restart pc", 32'(trace[0].i_addr), 32'(0));
    checkOutput("mid-load second fetch", 32'(trace[3].i_addr), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
